// File: rtl/l2arb_pkg.sv
// l2arb_pkg: shared types for the L1 I/D to L2 Wishbone arbiter.
//   arb_state_t : arbiter FSM states (idle, serving I-cache, serving D-cache)
//   master_t    : identifies one of the two L1 masters
//   serve_state : maps a granted master onto the state that serves it
package l2arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 256;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        M_I,
        M_D
    } master_t;

    function automatic arb_state_t serve_state(input master_t m);
        return (m == M_D) ? SERVE_D : SERVE_I;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick.
//   req_i, req_d : request lines from the I-cache and D-cache
//   last_grant   : master that completed the most recent transaction
//   valid        : at least one master is requesting
//   winner       : chosen master (meaningful only when valid)
module rr_pick2
    import l2arb_pkg::*;
(
    input  logic    req_i,
    input  logic    req_d,
    input  master_t last_grant,
    output logic    valid,
    output master_t winner
);

    always_comb begin
        valid  = req_i | req_d;
        winner = M_I;
        if (req_i && req_d) begin
            // On a tie the master that was not served last goes first.
            winner = (last_grant == M_I) ? M_D : M_I;
        end else if (req_d) begin
            winner = M_D;
        end
    end

endmodule

// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: two-master Wishbone arbiter in front of the L2 CPU port.
// Multiplexes L1 I-cache and D-cache line requests onto one L2 port with
// round-robin fairness, holding the granted address/data stable for the
// whole L2 transaction and routing ack/read data back to the owner.
//   clk, rst                 : clock, synchronous active-high reset
//   i_cyc/i_stb/i_adr        : I-cache request (read only)
//   i_ack/i_dat_r            : I-cache response
//   d_cyc/d_stb/d_we/d_adr/d_dat_w : D-cache request (read or writeback)
//   d_ack/d_dat_r            : D-cache response
//   l2_cyc/l2_stb/l2_we/l2_adr/l2_dat_w : request to L2
//   l2_ack/l2_dat_r          : response from L2
module l1_l2_arbiter
    import l2arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_cyc,
    input  logic              i_stb,
    input  logic [ADDR_W-1:0] i_adr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_dat_r,

    input  logic              d_cyc,
    input  logic              d_stb,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [DATA_W-1:0] d_dat_w,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_dat_r,

    output logic              l2_cyc,
    output logic              l2_stb,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_adr,
    output logic [DATA_W-1:0] l2_dat_w,
    input  logic              l2_ack,
    input  logic [DATA_W-1:0] l2_dat_r
);

    arb_state_t        state_q, state_d;
    master_t           last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] hold_adr_q, hold_adr_d;
    logic              hold_we_q, hold_we_d;
    logic [DATA_W-1:0] hold_dat_q, hold_dat_d;

    logic              req_i, req_d;
    logic              pick_valid;
    master_t           pick_winner;

    assign req_i = i_cyc & i_stb;
    assign req_d = d_cyc & d_stb;

    rr_pick2 u_pick (
        .req_i      (req_i),
        .req_d      (req_d),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= M_I;
            hold_adr_q   <= '0;
            hold_we_q    <= 1'b0;
            hold_dat_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            hold_adr_q   <= hold_adr_d;
            hold_we_q    <= hold_we_d;
            hold_dat_q   <= hold_dat_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        hold_adr_d   = hold_adr_q;
        hold_we_d    = hold_we_q;
        hold_dat_d   = hold_dat_q;

        l2_cyc   = 1'b0;
        l2_stb   = 1'b0;
        l2_we    = 1'b0;
        l2_adr   = '0;
        l2_dat_w = '0;
        i_ack    = 1'b0;
        d_ack    = 1'b0;
        i_dat_r  = '0;
        d_dat_r  = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = serve_state(pick_winner);
                    if (pick_winner == M_D) begin
                        hold_adr_d = d_adr;
                        hold_we_d  = d_we;
                        hold_dat_d = d_dat_w;
                    end else begin
                        // I-cache only fetches lines; never forward a write.
                        hold_adr_d = i_adr;
                        hold_we_d  = 1'b0;
                        hold_dat_d = '0;
                    end
                end
            end

            SERVE_I: begin
                l2_cyc   = 1'b1;
                l2_stb   = 1'b1;
                l2_we    = hold_we_q;
                l2_adr   = hold_adr_q;
                l2_dat_w = hold_dat_q;
                i_dat_r  = l2_dat_r;
                if (!i_cyc) begin
                    // Master abandoned the cycle: drop it without an ack or
                    // a fairness update.
                    state_d = IDLE;
                end else if (l2_ack) begin
                    i_ack        = 1'b1;
                    last_grant_d = M_I;
                    state_d      = IDLE;
                end
            end

            SERVE_D: begin
                l2_cyc   = 1'b1;
                l2_stb   = 1'b1;
                l2_we    = hold_we_q;
                l2_adr   = hold_adr_q;
                l2_dat_w = hold_dat_q;
                d_dat_r  = l2_dat_r;
                if (!d_cyc) begin
                    state_d = IDLE;
                end else if (l2_ack) begin
                    d_ack        = 1'b1;
                    last_grant_d = M_D;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
